cam_bit_deser: RTL and testbench

- Front end of the camera path into the NICE accelerator.
- Consumes the 1-bit-per-clock serial camera stream i_cam_data while the accelerator signals readiness.
- Packs bits into 32-bit words, tags start and end of frame, and buffers words in a small FIFO.
- The accelerator drains the FIFO through a valid/ready handshake.
- One frame is FRAME_BITS bits; the final partial word is zero-padded.

---
 rtl/cam_bit_deser_pkg.sv | 23 ++
 rtl/cam_bit_deser_if.sv | 16 +
 rtl/cam_deser_fifo.sv | 48 ++++
 rtl/cam_bit_deser.sv | 165 ++++++++++++++++
 tb/tb_cam_bit_deser.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_bit_deser_pkg.sv
// Shared types and constants for the camera bit deserializer: word/tag widths,
// default frame length and the packer FSM state encoding.
package cam_bit_deser_pkg;

  localparam int WORD_W         = 32;
  localparam int TAG_W          = 2;
  localparam int ENTRY_W        = WORD_W + TAG_W;
  localparam int FRAME_BITS_DEF = 15440;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // One FIFO entry: packed word plus start/end-of-frame tags.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sof;
    logic              eof;
  } word_t;

endpackage

// File: rtl/cam_bit_deser_if.sv
// Word stream from the deserializer to the accelerator: valid/ready handshake
// carrying a 32-bit word with sof/eof tags.
interface cam_bit_deser_if;
  import cam_bit_deser_pkg::*;

  logic              o_word_valid;
  logic              i_word_ready;
  logic [WORD_W-1:0] o_word_data;
  logic              o_word_sof;
  logic              o_word_eof;

  modport master (output o_word_valid, o_word_data, o_word_sof, o_word_eof,
                  input  i_word_ready);
  modport slave  (input  o_word_valid, o_word_data, o_word_sof, o_word_eof,
                  output i_word_ready);
endinterface

// File: rtl/cam_deser_fifo.sv
// Synchronous FIFO for tagged camera words; write-to-visible latency of one
// cycle, no bypass, head data forced to zero while empty.
module cam_deser_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cam_bit_deser.sv
// Serial camera stream to 32-bit tagged words with output FIFO.
// Optional statistics counters (drop_cnt, frame_cnt) under `CAM_DESER_STAT_EN.
module cam_bit_deser
  import cam_bit_deser_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cam_en,
  input  logic                   i_cam_data,
  input  logic                   clr_status,
  cam_bit_deser_if.master        word_if,
  output logic                   o_frame_done,
  output logic                   o_overflow,
  output logic                   o_abort
`ifdef CAM_DESER_STAT_EN
  ,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            frame_cnt
`endif
);

  localparam int CNT_W     = $clog2(FRAME_BITS);
  localparam int PART_BITS = FRAME_BITS % WORD_W;
  localparam int PAD       = (PART_BITS == 0) ? 0 : WORD_W - PART_BITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt, shifted;
  logic              first_word, first_nxt;
  logic              push, done_nxt, abort_nxt;
  word_t             push_entry, head;
  logic              fifo_full, fifo_empty, pop, drop;

  assign shifted = MSB_FIRST ? {shreg[WORD_W-2:0], i_cam_data}
                             : {i_cam_data, shreg[WORD_W-1:1]};

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    first_nxt  = first_word;
    push       = 1'b0;
    push_entry = '0;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cam_en) begin
          shreg_nxt = shifted;
          cnt_nxt   = CNT_W'(1);
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!cam_en) begin
          abort_nxt = 1'b1;
          cnt_nxt   = '0;
          shreg_nxt = '0;
          first_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          shreg_nxt = shifted;
          cnt_nxt   = bit_cnt + CNT_W'(1);
          if (bit_cnt[4:0] == 5'd31) begin
            push            = 1'b1;
            push_entry.data = shifted;
            push_entry.sof  = first_word;
            push_entry.eof  = (bit_cnt == LAST_IDX);
            first_nxt       = 1'b0;
          end
          if (bit_cnt == LAST_IDX) begin
            cnt_nxt = '0;
            if (PART_BITS == 0) begin
              done_nxt  = 1'b1;
              first_nxt = 1'b1;
              shreg_nxt = '0;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        // The partial word's valid bits sit at the shift-in end; move them to the frame-order end.
        push            = 1'b1;
        push_entry.data = MSB_FIRST ? (shreg << PAD) : (shreg >> PAD);
        push_entry.sof  = first_word;
        push_entry.eof  = 1'b1;
        done_nxt        = 1'b1;
        first_nxt       = 1'b1;
        shreg_nxt       = '0;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pop  = !fifo_empty && word_if.i_word_ready;
  assign drop = push && fifo_full && !pop;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      first_word   <= 1'b1;
      o_frame_done <= 1'b0;
      o_abort      <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= cnt_nxt;
      shreg        <= shreg_nxt;
      first_word   <= first_nxt;
      o_frame_done <= done_nxt;
      o_abort      <= abort_nxt;
      if (drop)            o_overflow <= 1'b1;
      else if (clr_status) o_overflow <= 1'b0;
    end
  end

`ifdef CAM_DESER_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (clr_status) begin
        drop_cnt <= '0;
      end
      if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  cam_deser_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_if.o_word_valid = !fifo_empty;
  assign word_if.o_word_data  = head.data;
  assign word_if.o_word_sof   = head.sof;
  assign word_if.o_word_eof   = head.eof;

endmodule

// File: tb/tb_cam_bit_deser.sv
// Self-checking bench for cam_bit_deser: random serial frames compared against a
// frame-level reference model; a 15440-bit main instance plus 48/64-bit small ones.
module tb_cam_bit_deser;
  import cam_bit_deser_pkg::*;

  localparam int FB = 15440;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cam_en, cam_data, clr_status, cam_en_s, data_s;
  logic frame_done, overflow, abort;
  logic done_b, ovf_b, abort_b, done_c, ovf_c, abort_c;
`ifdef CAM_DESER_STAT_EN
  logic [15:0] drop_cnt, frame_cnt, drop_b, fcnt_b, drop_c, fcnt_c;
`endif

  cam_bit_deser_if main_if();
  cam_bit_deser_if ifb();
  cam_bit_deser_if ifc();
  assign ifb.i_word_ready = 1'b1;
  assign ifc.i_word_ready = 1'b1;

  cam_bit_deser #(.FRAME_BITS(FB), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .cam_en(cam_en), .i_cam_data(cam_data), .clr_status(clr_status),
    .word_if(main_if), .o_frame_done(frame_done), .o_overflow(overflow), .o_abort(abort)
`ifdef CAM_DESER_STAT_EN
    , .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
`endif
  );

  cam_bit_deser #(.FRAME_BITS(48), .FIFO_DEPTH(2), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cam_en(cam_en_s), .i_cam_data(data_s), .clr_status(1'b0),
    .word_if(ifb), .o_frame_done(done_b), .o_overflow(ovf_b), .o_abort(abort_b)
`ifdef CAM_DESER_STAT_EN
    , .drop_cnt(drop_b), .frame_cnt(fcnt_b)
`endif
  );

  cam_bit_deser #(.FRAME_BITS(64), .FIFO_DEPTH(2), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .cam_en(cam_en_s), .i_cam_data(data_s), .clr_status(1'b0),
    .word_if(ifc), .o_frame_done(done_c), .o_overflow(ovf_c), .o_abort(abort_c)
`ifdef CAM_DESER_STAT_EN
    , .drop_cnt(drop_c), .frame_cnt(fcnt_c)
`endif
  );

  // Monitors only ever append or count; the main sequence reads them by offset.
  exp_t rx_main[$], rx_b[$], rx_c[$];
  int done_main = 0, abort_main = 0, n_done_b = 0, n_abort_b = 0, n_done_c = 0, n_abort_c = 0;

  always @(posedge clk) begin
    if (main_if.o_word_valid && main_if.i_word_ready)
      rx_main.push_back('{data: main_if.o_word_data, sof: main_if.o_word_sof, eof: main_if.o_word_eof});
    if (ifb.o_word_valid)
      rx_b.push_back('{data: ifb.o_word_data, sof: ifb.o_word_sof, eof: ifb.o_word_eof});
    if (ifc.o_word_valid)
      rx_c.push_back('{data: ifc.o_word_data, sof: ifc.o_word_sof, eof: ifc.o_word_eof});
    if (frame_done) done_main  <= done_main + 1;
    if (abort)      abort_main <= abort_main + 1;
    if (done_b)     n_done_b   <= n_done_b + 1;
    if (abort_b)    n_abort_b  <= n_abort_b + 1;
    if (done_c)     n_done_c   <= n_done_c + 1;
    if (abort_c)    n_abort_c  <= n_abort_c + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one continuous cam_en burst -> expected words, frames and aborts.
  exp_t mq[$];
  int   m_done, m_abort;

  function automatic void model_burst(input bit bits[$], input int fb, input bit msb);
    int i, n, take, nw;
    bit complete;
    exp_t w;
    mq.delete();
    m_done = 0;
    m_abort = 0;
    i = 0;
    n = bits.size();
    while (i < n) begin
      take     = (n - i < fb) ? n - i : fb;
      complete = (take == fb);
      nw       = complete ? (fb + 31) / 32 : take / 32;
      for (int k = 0; k < nw; k++) begin
        w.data = '0;
        for (int j = 0; j < 32; j++)
          if (32 * k + j < take && bits[i + 32 * k + j]) begin
            if (msb) w.data[31 - j] = 1'b1;
            else     w.data[j]      = 1'b1;
          end
        w.sof = (k == 0);
        w.eof = complete && (k == nw - 1);
        mq.push_back(w);
      end
      if (complete) begin
        m_done++;
        i += fb + ((fb % 32 != 0) ? 1 : 0);  // the flush cycle swallows one bit
      end else begin
        m_abort++;
        i = n;
      end
    end
  endfunction

  task automatic check_words(input string tag, input exp_t got[$], input int base, input int n);
    int n_bad, first_bad;
    n_bad = 0;
    first_bad = -1;
    check({tag, "_count"}, 64'(got.size() - base), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k >= got.size()) break;
      if (got[base+k].data !== mq[k].data || got[base+k].sof !== mq[k].sof ||
          got[base+k].eof !== mq[k].eof) begin
        if (first_bad < 0) first_bad = k;
        n_bad++;
      end
    end
    check($sformatf("%s_bad_words_first%0d", tag, first_bad), 64'(n_bad), 64'd0);
  endtask

  task automatic drive_main(input bit bits[$]);
    foreach (bits[i]) begin
      @(negedge clk);
      cam_en   = 1'b1;
      cam_data = bits[i];
    end
    @(negedge clk);
    cam_en   = 1'b0;
    cam_data = 1'b0;
  endtask

  task automatic drive_small(input bit bits[$]);
    foreach (bits[i]) begin
      @(negedge clk);
      cam_en_s = 1'b1;
      data_s   = bits[i];
    end
    @(negedge clk);
    cam_en_s = 1'b0;
    data_s   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bits[$];
    int base, bb, bc, d0, a0, db, ab, dc, ac;
    rst = 1'b1; cam_en = 1'b0; cam_data = 1'b0; clr_status = 1'b0;
    cam_en_s = 1'b0; data_s = 1'b0; main_if.i_word_ready = 1'b0;
    idle(3);
    check("rst_valid", main_if.o_word_valid, 0);
    check("rst_data", main_if.o_word_data, 0);
    check("rst_sof_eof", {main_if.o_word_sof, main_if.o_word_eof}, 0);
    check("rst_pulses", {frame_done, abort, overflow}, 0);
    check("rst_small", {ifb.o_word_valid, ifc.o_word_valid, done_b, abort_c}, 0);
`ifdef CAM_DESER_STAT_EN
    check("rst_stats", {drop_cnt, frame_cnt}, 0);
`endif
    rst = 1'b0;

    // Clean frame, alternating pattern, consumer always ready
    main_if.i_word_ready = 1'b1;
    bits.delete();
    for (int n = 0; n < FB; n++) bits.push_back(n[0]);
    model_burst(bits, FB, 1'b1);
    base = rx_main.size(); d0 = done_main; a0 = abort_main;
    drive_main(bits);
    idle(8);
    check_words("clean", rx_main, base, 483);
    check("clean_w0", {rx_main[base].data, rx_main[base].sof}, {32'h55555555, 1'b1});
    check("clean_w482", {rx_main[base+482].data, rx_main[base+482].eof}, {32'h55550000, 1'b1});
    check("clean_done", 64'(done_main - d0), 1);
    check("clean_abort", 64'(abort_main - a0), 0);
    check("clean_ovf", overflow, 0);
`ifdef CAM_DESER_STAT_EN
    check("clean_frame_cnt", frame_cnt, 1);
`endif

    // Backpressure for the whole random frame
    main_if.i_word_ready = 1'b0;
    bits.delete();
    for (int n = 0; n < FB; n++) bits.push_back(1'($urandom));
    model_burst(bits, FB, 1'b1);
    base = rx_main.size(); d0 = done_main;
    foreach (bits[i]) begin
      @(negedge clk);
      if (i == 159) check("bp_ovf_before_5th", overflow, 0);
      if (i == 160) check("bp_ovf_after_5th", overflow, 1);
      cam_en   = 1'b1;
      cam_data = bits[i];
    end
    @(negedge clk);
    cam_en = 1'b0;
    idle(4);
    check("bp_no_pops", 64'(rx_main.size() - base), 0);
    check("bp_head", {main_if.o_word_valid, main_if.o_word_data, main_if.o_word_sof, main_if.o_word_eof},
          {1'b1, mq[0].data, 2'b10});
    check("bp_done", 64'(done_main - d0), 1);
`ifdef CAM_DESER_STAT_EN
    check("bp_drop_cnt", drop_cnt, 479);
`endif
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("bp_ovf_cleared", overflow, 0);
`ifdef CAM_DESER_STAT_EN
    check("bp_drop_cleared", drop_cnt, 0);
`endif
    main_if.i_word_ready = 1'b1;
    idle(8);
    check_words("bp_drain", rx_main, base, 4);

    // Abort after 40 bits, then a fresh frame start
    bits.delete();
    for (int n = 0; n < 40; n++) bits.push_back(1'($urandom));
    model_burst(bits, FB, 1'b1);
    base = rx_main.size(); d0 = done_main; a0 = abort_main;
    drive_main(bits);
    idle(4);
    check_words("abort", rx_main, base, mq.size());
    check("abort_pulse", 64'(abort_main - a0), 1);
    check("abort_no_done", 64'(done_main - d0), 0);
    bits.delete();
    for (int n = 0; n < 33; n++) bits.push_back(1'($urandom));
    model_burst(bits, FB, 1'b1);
    base = rx_main.size();
    drive_main(bits);
    idle(4);
    check_words("reenable", rx_main, base, mq.size());
    check("reenable_sof", rx_main[base].sof, 1);

    // Back-to-back frames with one flush-swallowed bit between them
    bits.delete();
    for (int n = 0; n < 2 * FB + 1; n++) bits.push_back(1'($urandom));
    model_burst(bits, FB, 1'b1);
    base = rx_main.size(); d0 = done_main; a0 = abort_main;
    drive_main(bits);
    idle(8);
    check_words("b2b", rx_main, base, 966);
    check("b2b_done", 64'(done_main - d0), 2);
    check("b2b_abort", 64'(abort_main - a0), 0);
    check("b2b_ovf", overflow, 0);

    // Reset at bit 1000 with three words held in the FIFO
    bits.delete();
    for (int n = 0; n < 1000; n++) bits.push_back(1'($urandom));
    foreach (bits[i]) begin
      @(negedge clk);
      if (i == 900) main_if.i_word_ready = 1'b0;
      cam_en   = 1'b1;
      cam_data = bits[i];
    end
    @(negedge clk);
    check("mid_rst_queued", main_if.o_word_valid, 1);
    d0 = done_main; a0 = abort_main;
    rst = 1'b1;
    cam_en = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {main_if.o_word_valid, main_if.o_word_data, main_if.o_word_sof,
                              main_if.o_word_eof, frame_done, abort, overflow}, 0);
    rst = 1'b0;
    main_if.i_word_ready = 1'b1;
    bits.delete();
    for (int n = 0; n < 34; n++) bits.push_back(1'($urandom));
    model_burst(bits, FB, 1'b1);
    base = rx_main.size();
    drive_main(bits);
    idle(4);
    check_words("post_rst", rx_main, base, 1);
    check("post_rst_events", {32'(done_main - d0), 32'(abort_main - a0)}, {32'd0, 32'(m_abort)});

    // Small instances: 48-bit LSB-first and 64-bit word-aligned MSB-first
    bits.delete();
    for (int n = 0; n < 48; n++) bits.push_back(1'b1);
    bb = rx_b.size(); bc = rx_c.size();
    db = n_done_b; ab = n_abort_b; dc = n_done_c; ac = n_abort_c;
    drive_small(bits);
    idle(6);
    model_burst(bits, 48, 1'b0);
    check_words("lsb48_ones", rx_b, bb, mq.size());
    check("lsb48_w0", {rx_b[bb].data, rx_b[bb].sof}, {32'hFFFFFFFF, 1'b1});
    check("lsb48_w1", {rx_b[bb+1].data, rx_b[bb+1].eof}, {32'h0000FFFF, 1'b1});
    check("lsb48_done", 64'(n_done_b - db), 1);
    model_burst(bits, 64, 1'b1);
    check_words("w64_partial", rx_c, bc, mq.size());
    check("w64_abort", 64'(n_abort_c - ac), 64'(m_abort));

    bits.delete();
    for (int n = 0; n < 200; n++) bits.push_back(1'($urandom));
    bb = rx_b.size(); bc = rx_c.size();
    db = n_done_b; ab = n_abort_b; dc = n_done_c; ac = n_abort_c;
    drive_small(bits);
    idle(6);
    model_burst(bits, 48, 1'b0);
    check_words("lsb48_rand", rx_b, bb, mq.size());
    check("lsb48_rand_events", {32'(n_done_b - db), 32'(n_abort_b - ab)}, {32'(m_done), 32'(m_abort)});
    model_burst(bits, 64, 1'b1);
    check_words("w64_rand", rx_c, bc, mq.size());
    check("w64_rand_events", {32'(n_done_c - dc), 32'(n_abort_c - ac)}, {32'(m_done), 32'(m_abort)});
    check("small_no_ovf", {ovf_b, ovf_c}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
